// File: rtl/intel_8042.sv
// Keyboard-controller front end: brings up the keyboard with F4/F0/01 commands,
// then forwards every received scan-code byte unchanged on a host-side serial line.
module intel_8042 (
  input  logic KBD_CLK,
  input  logic KBD_RESET_N,
  output logic KBD_DATA,
  inout  wire  KEYBOARD_CLK_0,
  inout  wire  KEYBOARD_DATA_0
);

  typedef enum logic [2:0] {
    S_RESET,
    S_SEND_F4,
    S_ACK1,
    S_SEND_F0,
    S_ACK2,
    S_SEND_01,
    S_ACK3,
    S_RUN
  } state_e;

  localparam logic [7:0] CMD_F4 = 8'hF4;
  localparam logic [7:0] CMD_F0 = 8'hF0;
  localparam logic [7:0] CMD_01 = 8'h01;
  localparam logic [7:0] ACK    = 8'hFA;

  state_e      state_q;

  // keyboard-side transmitter
  logic        tx_en_q;
  logic        tx_guard_q;
  logic [3:0]  tx_cnt_q;
  logic [9:0]  tx_shift_q;

  // keyboard-side receiver
  logic        rx_active_q;
  logic [3:0]  rx_cnt_q;
  logic [7:0]  rx_shift_q;
  logic [7:0]  rx_byte_q;
  logic        rx_valid_q;
  logic        rx_en;
  logic        kbd_in;

  // holding register and host-side transmitter
  logic [7:0]  hold_q, hold_d;
  logic        hold_full_q, hold_full_d;
  logic        ho_load_d;
  logic [7:0]  ho_byte_d;
  logic        ho_busy_q;
  logic [3:0]  ho_cnt_q;
  logic [9:0]  ho_shift_q;
  logic        kbd_data_q;
  logic        fwd;

  assign KEYBOARD_CLK_0  = 1'bz;
  assign KEYBOARD_DATA_0 = tx_en_q ? tx_shift_q[0] : 1'bz;
  assign KBD_DATA        = kbd_data_q;

  assign kbd_in = KEYBOARD_DATA_0;
  assign rx_en  = !tx_en_q && !tx_guard_q;

  // Init sequencer and command transmitter share one block so a SEND state
  // launches its frame on the same edge it hands over to the ACK state.
  always_ff @(posedge KBD_CLK or posedge KBD_RESET_N) begin
    if (KBD_RESET_N) begin
      state_q    <= S_RESET;
      tx_en_q    <= 1'b0;
      tx_guard_q <= 1'b0;
      tx_cnt_q   <= '0;
      tx_shift_q <= '1;
    end else begin
      tx_guard_q <= 1'b0;
      if (tx_en_q) begin
        if (tx_cnt_q == 4'd9) begin
          tx_en_q    <= 1'b0;
          tx_guard_q <= 1'b1;
          tx_shift_q <= '1;
        end else begin
          tx_shift_q <= {1'b1, tx_shift_q[9:1]};
          tx_cnt_q   <= tx_cnt_q + 4'd1;
        end
      end

      case (state_q)
        S_RESET: state_q <= S_SEND_F4;
        S_SEND_F4: begin
          tx_en_q    <= 1'b1;
          tx_cnt_q   <= '0;
          tx_shift_q <= {~^CMD_F4, CMD_F4, 1'b0};
          state_q    <= S_ACK1;
        end
        S_SEND_F0: begin
          tx_en_q    <= 1'b1;
          tx_cnt_q   <= '0;
          tx_shift_q <= {~^CMD_F0, CMD_F0, 1'b0};
          state_q    <= S_ACK2;
        end
        S_SEND_01: begin
          tx_en_q    <= 1'b1;
          tx_cnt_q   <= '0;
          tx_shift_q <= {~^CMD_01, CMD_01, 1'b0};
          state_q    <= S_ACK3;
        end
        S_ACK1: if (rx_valid_q) state_q <= (rx_byte_q == ACK) ? S_SEND_F0 : S_SEND_F4;
        S_ACK2: if (rx_valid_q) state_q <= (rx_byte_q == ACK) ? S_SEND_01 : S_SEND_F0;
        S_ACK3: if (rx_valid_q) state_q <= (rx_byte_q == ACK) ? S_RUN : S_SEND_01;
        S_RUN:   state_q <= S_RUN;
        default: state_q <= S_RESET;
      endcase
    end
  end

  // Receiver: start on a sampled 0, eight data bits, parity and stop taken blind.
  always_ff @(posedge KBD_CLK or posedge KBD_RESET_N) begin
    if (KBD_RESET_N) begin
      rx_active_q <= 1'b0;
      rx_cnt_q    <= '0;
      rx_shift_q  <= '0;
      rx_byte_q   <= '0;
      rx_valid_q  <= 1'b0;
    end else begin
      rx_valid_q <= 1'b0;
      if (!rx_active_q) begin
        if (rx_en && kbd_in == 1'b0) begin
          rx_active_q <= 1'b1;
          rx_cnt_q    <= 4'd1;
        end
      end else begin
        if (rx_cnt_q <= 4'd8) begin
          rx_shift_q <= {kbd_in, rx_shift_q[7:1]};
        end
        if (rx_cnt_q == 4'd10) begin
          rx_active_q <= 1'b0;
          rx_cnt_q    <= '0;
          rx_byte_q   <= rx_shift_q;
          rx_valid_q  <= 1'b1;
        end else begin
          rx_cnt_q <= rx_cnt_q + 4'd1;
        end
      end
    end
  end

  // A held byte always goes out before a fresh one; a fresh byte that cannot
  // go out now replaces whatever is held.
  always_comb begin
    fwd         = rx_valid_q && (state_q == S_RUN);
    ho_load_d   = 1'b0;
    ho_byte_d   = hold_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    if (!ho_busy_q) begin
      if (hold_full_q) begin
        ho_load_d   = 1'b1;
        ho_byte_d   = hold_q;
        hold_full_d = 1'b0;
      end else if (fwd) begin
        ho_load_d = 1'b1;
        ho_byte_d = rx_byte_q;
      end
    end
    if (fwd && (ho_busy_q || hold_full_q)) begin
      hold_d      = rx_byte_q;
      hold_full_d = 1'b1;
    end
  end

  // Host frame: first start bit on load, then second start, D0..D7 and one
  // high guard cycle before the next load is allowed.
  always_ff @(posedge KBD_CLK or posedge KBD_RESET_N) begin
    if (KBD_RESET_N) begin
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      ho_busy_q   <= 1'b0;
      ho_cnt_q    <= '0;
      ho_shift_q  <= '1;
      kbd_data_q  <= 1'b1;
    end else begin
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      if (ho_load_d) begin
        ho_busy_q  <= 1'b1;
        ho_cnt_q   <= '0;
        ho_shift_q <= {1'b1, ho_byte_d, 1'b0};
        kbd_data_q <= 1'b0;
      end else if (ho_busy_q) begin
        kbd_data_q <= ho_shift_q[0];
        ho_shift_q <= {1'b1, ho_shift_q[9:1]};
        ho_cnt_q   <= ho_cnt_q + 4'd1;
        if (ho_cnt_q == 4'd9) begin
          ho_busy_q <= 1'b0;
        end
      end else begin
        kbd_data_q <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_intel_8042.sv
// Scoreboard bench for intel_8042: expected command and host bytes are queued
// as stimulus is applied and consumed by line monitors.
module tb_intel_8042;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic kbd_data;
  logic tb_drv = 1'b0;
  logic tb_bit = 1'b1;
  wire  kdat;
  wire  kclk;

  pullup (kdat);
  pullup (kclk);
  assign kdat = tb_drv ? tb_bit : 1'bz;

  always #5 clk = ~clk;

  intel_8042 dut (
    .KBD_CLK        (clk),
    .KBD_RESET_N    (rst),
    .KBD_DATA       (kbd_data),
    .KEYBOARD_CLK_0 (kclk),
    .KEYBOARD_DATA_0(kdat)
  );

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0] cmd_q[$];
  logic [7:0] host_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Command monitor: frames on the keyboard data line not driven by the bench.
  int         c_cnt = 0;
  logic [7:0] c_byte;
  logic       c_par;
  logic [7:0] c_exp;
  always @(negedge clk) begin
    if (rst) begin
      c_cnt = 0;
    end else if (c_cnt == 0) begin
      if (!tb_drv && kdat === 1'b0) c_cnt = 1;
    end else if (c_cnt <= 8) begin
      c_byte = {kdat, c_byte[7:1]};
      c_cnt++;
    end else if (c_cnt == 9) begin
      c_par = kdat;
      c_cnt = 10;
    end else begin
      check("cmd_release", {31'd0, kdat}, 32'd1);
      check("cmd_pending", {31'd0, cmd_q.size() > 0}, 32'd1);
      if (cmd_q.size() > 0) begin
        c_exp = cmd_q.pop_front();
        check("cmd_byte", {24'd0, c_byte}, {24'd0, c_exp});
        check("cmd_parity", {31'd0, c_par}, {31'd0, ~^c_exp});
      end
      c_cnt = 0;
    end
  end

  // Host-line monitor.
  int         h_cnt = 0;
  logic [7:0] h_byte;
  logic [7:0] h_exp;
  always @(negedge clk) begin
    if (rst) begin
      h_cnt = 0;
    end else if (h_cnt == 0) begin
      if (kbd_data === 1'b0) h_cnt = 1;
    end else if (h_cnt == 1) begin
      check("host_start2", {31'd0, kbd_data}, 32'd0);
      h_cnt = 2;
    end else if (h_cnt <= 9) begin
      h_byte = {kbd_data, h_byte[7:1]};
      h_cnt++;
    end else begin
      check("host_gap", {31'd0, kbd_data}, 32'd1);
      check("host_pending", {31'd0, host_q.size() > 0}, 32'd1);
      if (host_q.size() > 0) begin
        h_exp = host_q.pop_front();
        check("host_byte", {24'd0, h_byte}, {24'd0, h_exp});
      end
      h_cnt = 0;
    end
  end

  task automatic kbd_send(input logic [7:0] b, input logic par);
    logic [10:0] fr;
    fr = {1'b1, par, b, 1'b0};
    for (int i = 0; i < 11; i++) begin
      tb_bit = fr[i];
      tb_drv = 1'b1;
      @(posedge clk); #1;
    end
    tb_drv = 1'b0;
    tb_bit = 1'b1;
  endtask

  task automatic wait_idle(input string tag, input int max_cyc);
    int n;
    n = 0;
    while ((cmd_q.size() != 0 || host_q.size() != 0 || c_cnt != 0 || h_cnt != 0) && n < max_cyc) begin
      @(posedge clk); #1;
      n++;
    end
    check(tag, cmd_q.size() + host_q.size(), 32'd0);
    repeat (3) begin @(posedge clk); #1; end
  endtask

  initial begin
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_kbd_data", {31'd0, kbd_data}, 32'd1);
    check("rst_kdat_released", {31'd0, kdat}, 32'd1);
    @(posedge clk); #1;
    cmd_q.push_back(8'hF4);
    rst = 1'b0;
    wait_idle("init_f4", 30);

    // non-ack in ACK1 repeats F4
    cmd_q.push_back(8'hF4);
    kbd_send(8'hAA, 1'b1);
    wait_idle("resend_f4", 40);

    cmd_q.push_back(8'hF0);
    kbd_send(8'hFA, 1'b1);
    wait_idle("send_f0", 40);

    cmd_q.push_back(8'h01);
    kbd_send(8'hFA, 1'b1);
    wait_idle("send_01", 40);

    // final ack enters RUN; nothing may appear on the host line
    kbd_send(8'hFA, 1'b1);
    repeat (30) begin @(posedge clk); #1; end
    check("run_quiet", {31'd0, kbd_data}, 32'd1);

    for (int i = 0; i < 256; i++) begin
      host_q.push_back(i[7:0]);
      kbd_send(i[7:0], 1'b1);
      repeat (2) begin @(posedge clk); #1; end
    end
    wait_idle("sweep", 60);

    host_q.push_back(8'h5A);
    host_q.push_back(8'hA5);
    kbd_send(8'h5A, 1'b0);
    kbd_send(8'hA5, 1'b1);
    wait_idle("back2back", 60);

    // reset in the middle of a host frame
    begin
      int n;
      host_q.push_back(8'h3C);
      kbd_send(8'h3C, 1'b1);
      n = 0;
      while (h_cnt < 4 && n < 40) begin @(negedge clk); n++; end
      check("midframe_reached", {31'd0, h_cnt >= 4}, 32'd1);
      rst = 1'b1;
      #1;
      check("midframe_rst_kbd_data", {31'd0, kbd_data}, 32'd1);
      check("midframe_rst_kdat", {31'd0, kdat}, 32'd1);
      host_q.delete();
      cmd_q.delete();
      repeat (3) @(posedge clk);
      #1;
      cmd_q.push_back(8'hF4);
      rst = 1'b0;
      wait_idle("reinit_f4", 30);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/intel_8042.md
INTEL_8042 -- requirements
Module: intel_8042

Interface
REQ-001 The block SHALL be a single-clock design: one clock and one reset, the reset being asynchronous and active-high.
REQ-002 KBD_CLK  input  1  system clock; one keyboard-side and one host-side serial bit per cycle; all logic on rising edge.
REQ-003 KBD_RESET_N  input  1  asynchronous, active-high reset (the suffix is historical; 1 = reset).
REQ-004 KBD_DATA  output  1  host-side serial scan-code output; idle high.
REQ-005 KEYBOARD_CLK_0  inout  1  keyboard clock pin; never driven (always Z); value ignored.
REQ-006 KEYBOARD_DATA_0  inout  1  bidirectional keyboard data; driven only while sending a command, otherwise Z (external pull-up).
REQ-007 Parameters: none.

Function
REQ-008 Keyboard receive frame, sampled one bit per KBD_CLK edge: start 0, D0..D7 LSB first, parity, stop.
REQ-009 Start is detected only when KEYBOARD_DATA_0 samples exactly 0; Z/1 = idle.
REQ-010 Parity and stop values are not checked; a frame is always accepted after 11 bits.
REQ-011 Receiver is disabled while the block drives KEYBOARD_DATA_0 and for 1 cycle after release.
REQ-012 Keyboard transmit frame: drive 0 (start) for 1 cycle, D0..D7 LSB first 1 cycle each, odd parity 1 cycle, then release to Z.
REQ-013 Host output frame on KBD_DATA: 0 for 2 cycles (start), D0..D7 LSB first 1 cycle each, then return high for at least 1 cycle before any next frame.
REQ-014 Init FSM states: RESET -> SEND_F4 -> ACK1 -> SEND_F0 -> ACK2 -> SEND_01 -> ACK3 -> RUN.
REQ-015 The first command (F4) transmit starts within 2 cycles of reset deassertion.
REQ-016 In ACKn, a received byte 0xFA advances to the next SEND state, whose transmit starts within 2 cycles of the ack stop bit.
REQ-017 In ACKn, a received byte other than 0xFA makes the block resend the same command.
REQ-018 Bytes received during init are never forwarded to KBD_DATA.
REQ-019 In RUN, every received byte 0x00..0xFF is forwarded unchanged (no translation; 0xF0 and 0xFA included).
REQ-020 In RUN, the output frame begins within 2 cycles of the byte's stop-bit sample.
REQ-021 A 1-byte holding register sits between receiver and transmitter.
REQ-022 A byte arriving while an output frame is active waits in the holding register and is sent after the current frame.
REQ-023 If the holding register is already full when a new byte arrives, the new byte overwrites it.
REQ-024 There is no timeout; the FSM waits indefinitely in ACKn.

Reset
REQ-025 While reset is asserted: KBD_DATA=1, KEYBOARD_DATA_0=Z, KEYBOARD_CLK_0=Z, FSM=RESET, shift registers and holding register cleared.
REQ-026 Reset asserted mid-frame (either direction) aborts immediately with lines released.
REQ-027 On reset deassertion, init restarts from SEND_F4.

Verification
REQ-028 Reset pulse -> within 30 cycles KEYBOARD_DATA_0 carries start 0 then 0xF4 LSB-first and parity 0, then Z; KBD_DATA stays high.
REQ-029 Keyboard sends 0xFA -> block sends 0xF0; next 0xFA -> block sends 0x01; next 0xFA -> RUN; no KBD_DATA activity throughout.
REQ-030 In ACK1, keyboard sends 0xAA -> 0xF4 is retransmitted.
REQ-031 In RUN, for i=0..255 keyboard sends byte i (parity bit 1) -> KBD_DATA frame, sampled 3..10 edges after its falling edge, equals i; zero mismatches.
REQ-032 In RUN, two back-to-back keyboard frames -> two complete KBD_DATA frames in order, separated by at least 1 high cycle.
REQ-033 Reset asserted during a KBD_DATA frame -> KBD_DATA high same cycle; after release, the F4 command is sent again.
